// File: rtl/sprite_pixel_fetch.sv
// Sprite pixel fetcher: req/ack sprite memory reads, 5-bit palette decode, output FIFO.
// Define SPRITE_FETCH_CACHE_EN to enable the one-word read cache (and flush).
module sprite_pixel_fetch #(
  parameter int         ADDR_W          = 19,
  parameter logic [4:0] TRANSPARENT_IDX = 5'd0,
  parameter int         FIFO_DEPTH      = 4
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [31:0]       spriteAddress,
  input  logic              flush,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [15:0]       mem_data,
  output logic              pix_valid,
  input  logic              pix_ready,
  output logic [4:0]        pixel,
  output logic              pix_opaque
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam logic [PW:0] CNT_FULL = (PW+1)'(FIFO_DEPTH);

  typedef enum logic {
    S_IDLE,
    S_READ
  } state_t;

  state_t            r_state;
  logic              r_sel;
  logic [4:0]        r_fifo [FIFO_DEPTH];
  logic [PW-1:0]     r_wp;
  logic [PW-1:0]     r_rp;
  logic [PW:0]       r_cnt;

  logic [ADDR_W-1:0] w_word;
  logic              w_bsel;
  logic              w_accept;
  logic              w_ack;
  logic              w_hit;
  logic [4:0]        w_hit_pix;
  logic [4:0]        w_ack_pix;
  logic              w_push;
  logic [4:0]        w_push_pix;
  logic              w_pop;
  logic              w_unused;

  assign w_word    = spriteAddress[ADDR_W:1];
  assign w_bsel    = spriteAddress[0];
  assign req_ready = (r_state == S_IDLE) && (r_cnt != CNT_FULL);
  assign w_accept  = req_valid && req_ready;
  assign w_ack     = (r_state == S_READ) && mem_ack;
  assign w_ack_pix = r_sel ? mem_data[12:8] : mem_data[4:0];

`ifdef SPRITE_FETCH_CACHE_EN
  logic              r_cv;
  logic              r_cflush;
  logic [ADDR_W-1:0] r_caddr;
  logic [15:0]       r_cdata;

  assign w_hit     = r_cv && (r_caddr == w_word) && !flush;
  assign w_hit_pix = w_bsel ? r_cdata[12:8] : r_cdata[4:0];
  assign w_unused  = ^{spriteAddress[31:ADDR_W+1],
                       mem_data[15:13], mem_data[7:5],
                       r_cdata[15:13], r_cdata[7:5]};

  // A flush seen at any point of a read keeps the refilled word invalid.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_cv     <= 1'b0;
      r_cflush <= 1'b0;
      r_caddr  <= '0;
      r_cdata  <= '0;
    end else if (w_ack) begin
      r_caddr  <= mem_addr;
      r_cdata  <= mem_data;
      r_cv     <= !flush && !r_cflush;
      r_cflush <= 1'b0;
    end else begin
      if (flush)
        r_cv <= 1'b0;
      if (flush && (r_state == S_READ))
        r_cflush <= 1'b1;
    end
  end
`else
  assign w_hit     = 1'b0;
  assign w_hit_pix = 5'd0;
  assign w_unused  = ^{flush, spriteAddress[31:ADDR_W+1],
                       mem_data[15:13], mem_data[7:5]};
`endif

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_state  <= S_IDLE;
      mem_rd   <= 1'b0;
      mem_addr <= '0;
      r_sel    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept && !w_hit) begin
            r_state  <= S_READ;
            mem_rd   <= 1'b1;
            mem_addr <= w_word;
            r_sel    <= w_bsel;
          end
        end
        S_READ: begin
          if (mem_ack) begin
            r_state <= S_IDLE;
            mem_rd  <= 1'b0;
          end
        end
        default: begin
          r_state <= S_IDLE;
          mem_rd  <= 1'b0;
        end
      endcase
    end
  end

  assign w_push     = (w_accept && w_hit) || w_ack;
  assign w_push_pix = w_ack ? w_ack_pix : w_hit_pix;
  assign pix_valid  = (r_cnt != '0);
  assign w_pop      = pix_valid && pix_ready;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++)
        r_fifo[i] <= '0;
    end else begin
      if (w_push) begin
        r_fifo[r_wp] <= w_push_pix;
        r_wp         <= r_wp + 1'b1;
      end
      if (w_pop)
        r_rp <= r_rp + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  assign pixel      = pix_valid ? r_fifo[r_rp] : 5'd0;
  assign pix_opaque = pix_valid && (pixel != TRANSPARENT_IDX);

endmodule

// File: doc/sprite_pixel_fetch.md
# sprite_pixel_fetch

Consumer side of the sprite address stream: takes per-pixel sprite ROM indices (the `spriteAddress` / `playerOn` pair the sprite address generators produce) and fetches the packed pixel data from sprite memory. Each fetch goes through a req/ack read handshake, and a one-word read cache serves adjacent pixels. The block decodes each pixel to a 5-bit palette index plus an opaque flag, and queues results in a small FIFO for the color mapper.

## Interface
Parameters:
- `ADDR_W`, 19: sprite memory word-address width.
- `TRANSPARENT_IDX`, 5'd0: palette index treated as transparent.
- `FIFO_DEPTH`, 4: output FIFO entries (power of two, ≥2).

Ports:
- `Clk`  in  1  block clock.
- `Reset`  in  1  asynchronous, active-high reset.
- `req_valid`  in  1  pixel request present (driven by playerOn qualification).
- `req_ready`  out  1  request accepted this cycle when high with `req_valid`.
- `spriteAddress`  in  32  pixel index into sprite memory.
- `flush`  in  1  invalidate read cache (sprite sheet swapped).
- `mem_rd`  out  1  read strobe, held until `mem_ack`.
- `mem_addr`  out  ADDR_W  word address, stable while `mem_rd` high.
- `mem_ack`  in  1  read complete; `mem_data` valid this cycle.
- `mem_data`  in  16  two pixels per word: bits [7:0] even pixel, [15:8] odd pixel.
- `pix_valid`  out  1  FIFO head valid.
- `pix_ready`  in  1  consumer pops head when high with `pix_valid`.
- `pixel`  out  5  palette index of FIFO head.
- `pix_opaque`  out  1  head pixel != `TRANSPARENT_IDX`.

## Operation
- Word address = `spriteAddress[ADDR_W:1]`; byte select = `spriteAddress[0]`; bits above ADDR_W are ignored.
- Pixel = selected byte [4:0]; byte bits [7:5] are ignored.
- FSM states:
  - IDLE: accepts requests.
  - READ: `mem_rd` high, waiting for `mem_ack`.
  - IDLE→READ on an accepted request that misses.
  - READ→IDLE on `mem_ack`.
- Hit: cache valid, cached word address equal to the request's, and `flush` low. On a hit the pixel is pushed to the FIFO in the acceptance cycle, with no memory access.
- Miss: word address and byte select are latched and the FSM enters READ. On `mem_ack` the `mem_data` word is written to the cache, the cache is set valid, and the selected pixel is pushed to the FIFO.
- `req_ready` = IDLE && FIFO count < FIFO_DEPTH. Push and pop in the same cycle are legal; count is unchanged.
- `flush`:
  - Clears cache valid.
  - Takes priority over a simultaneous hit, so that request is treated as a miss.
  - During READ, the returning word is still pushed, but the cache stays invalid.
- Order is preserved: the FIFO output order equals the request acceptance order.

## Timing
- Reset (asynchronous): state IDLE, `mem_rd`=0, `mem_addr`=0, cache invalid, FIFO empty.
- Reset output values: `pix_valid`=0, `pixel`=0, `pix_opaque`=0, `req_ready`=1 after release.
- Hit latency: accepted in cycle N, `pix_valid` high in cycle N+1.
- Miss latency:
  - `mem_rd` rises in cycle N+1 and holds `mem_addr` until `mem_ack` is sampled in cycle M.
  - `mem_rd` low in cycle M+1; `pix_valid` in M+1; `req_ready` returns in M+1 if the FIFO is not full.
- Back-to-back hits sustain 1 pixel/cycle while the FIFO drains.
- `mem_ack` while not in READ is ignored.
- Reset mid-read abandons the read; a late `mem_ack` after reset is ignored.
- FIFO full: `req_ready` low. A pop in the same cycle does not make room until the next cycle.
- `pixel`/`pix_opaque` are stable while `pix_valid` && !`pix_ready`.

## Configuration
- `SPRITE_FETCH_CACHE_EN` defined: one-word read cache as described.
- Not defined:
  - Every accepted request is a miss and goes through READ.
  - `flush` is ignored.
  - Throughput is at most one pixel per memory round trip.

## Test plan
- Reset with `pix_ready`=1, request addr 0x10, `mem_ack` 2 cycles after `mem_rd` with data 0x1F03 → `mem_addr`=0x8, then pixel 3, opaque 1.
- Follow-up request addr 0x11 → no `mem_rd`, pixel 0x1F at the next cycle.
- Requests 0x20, 0x21, 0x22 with data 0x0500 for word 0x10 → pixels 0 (opaque 0) and 5 from one read; a second read at word 0x11.
- Hold `pix_ready`=0 and issue 5 cached hits → `req_ready` drops after the 4th; 4 entries retained and popped in order.
- Assert `flush` together with a hit request to addr 0x11 → a memory read to word 0x8 is issued.
- Assert `Reset` while `mem_rd` is high, then pulse `mem_ack` → `mem_rd`=0 immediately, FIFO empty, no pixel pushed.
- Build without `SPRITE_FETCH_CACHE_EN`, requests 0x10, 0x11 → two memory reads to word 0x8.
